// File: rtl/hazard_bypass_ctrl_if.sv
// Bypass/hazard interface between the ID stage and the hazard controller.
// The master side is the pipeline: it presents the ID instruction and the
// flush/stall sources. The slave side is the controller: it returns the
// bypass selects and the stall/bubble controls.
interface hazard_bypass_ctrl_if #(
    parameter int REG_AW = 4
);
    logic              vld_ID;
    logic              re0_ID;
    logic              re1_ID;
    logic [REG_AW-1:0] p0_addr_ID;
    logic [REG_AW-1:0] p1_addr_ID;
    logic              we_ID;
    logic [REG_AW-1:0] dst_addr_ID;
    logic              ld_ID;
    logic              flush;
    logic              stall_mem;
    logic              byp0_EX;
    logic              byp0_DM;
    logic              byp1_EX;
    logic              byp1_DM;
    logic              stall_IF_ID;
    logic              stall_ID_EX;
    logic              stall_EX_DM;
    logic              bubble_ID_EX;

    modport master (
        output vld_ID, re0_ID, re1_ID, p0_addr_ID, p1_addr_ID,
               we_ID, dst_addr_ID, ld_ID, flush, stall_mem,
        input  byp0_EX, byp0_DM, byp1_EX, byp1_DM,
               stall_IF_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX
    );

    modport slave (
        input  vld_ID, re0_ID, re1_ID, p0_addr_ID, p1_addr_ID,
               we_ID, dst_addr_ID, ld_ID, flush, stall_mem,
        output byp0_EX, byp0_DM, byp1_EX, byp1_DM,
               stall_IF_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX
    );
endinterface

// File: rtl/hazard_bypass_ctrl.sv
// ID-stage hazard and forwarding controller. Shadows the destination of the
// instructions in EX and DM, registers the EX-stage bypass selects, detects
// load-use hazards (one-cycle ID hold plus an ID_EX bubble) and fans out the
// pipeline stall controls.
module hazard_bypass_ctrl #(
    parameter int REG_AW   = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    hazard_bypass_ctrl_if.slave bus
);

    // EX-stage and DM-stage shadows of the in-flight producers
    logic              we_EX;
    logic              ld_EX;
    logic [REG_AW-1:0] dst_EX;
    logic              we_DM;
    logic [REG_AW-1:0] dst_DM;

    // Registered bypass selects seen by the EX-stage muxes
    logic byp0_EX_q;
    logic byp0_DM_q;
    logic byp1_EX_q;
    logic byp1_DM_q;

    logic hit0_EX;
    logic hit1_EX;
    logic hit0_DM;
    logic hit1_DM;
    logic load_use;
    logic bubble;
    logic nxt_byp0_EX;
    logic nxt_byp1_EX;

    // A read address matches a producer only if it writes that register and,
    // with a hardwired R0, the register is not R0.
    function automatic logic match(input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] d,
                                   input logic              w);
        return w && (a == d) && !(ZERO_REG && (a == '0));
    endfunction

    // Source-operand matches against EX/DM producers, load-use and bubble decode
    always_comb begin
        hit0_EX     = bus.re0_ID && match(bus.p0_addr_ID, dst_EX, we_EX);
        hit1_EX     = bus.re1_ID && match(bus.p1_addr_ID, dst_EX, we_EX);
        hit0_DM     = bus.re0_ID && match(bus.p0_addr_ID, dst_DM, we_DM);
        hit1_DM     = bus.re1_ID && match(bus.p1_addr_ID, dst_DM, we_DM);
        load_use    = bus.vld_ID && ld_EX && !bus.flush && (hit0_EX || hit1_EX);
        bubble      = !bus.stall_mem && (load_use || bus.flush);
        nxt_byp0_EX = bus.vld_ID && hit0_EX;
        nxt_byp1_EX = bus.vld_ID && hit1_EX;
    end

    // Shadow advance and bypass-select registration; memory stall freezes all
    always_ff @(posedge clk) begin
        if (rst) begin
            we_EX     <= 1'b0;
            ld_EX     <= 1'b0;
            dst_EX    <= '0;
            we_DM     <= 1'b0;
            dst_DM    <= '0;
            byp0_EX_q <= 1'b0;
            byp0_DM_q <= 1'b0;
            byp1_EX_q <= 1'b0;
            byp1_DM_q <= 1'b0;
        end else if (bus.stall_mem) begin
            // whole pipeline frozen: hold everything
        end else if (bubble) begin
            // NOP enters EX; the old EX producer still moves on to DM
            we_EX     <= 1'b0;
            ld_EX     <= 1'b0;
            we_DM     <= we_EX;
            dst_DM    <= dst_EX;
            byp0_EX_q <= 1'b0;
            byp0_DM_q <= 1'b0;
            byp1_EX_q <= 1'b0;
            byp1_DM_q <= 1'b0;
        end else begin
            we_EX     <= bus.vld_ID && bus.we_ID;
            ld_EX     <= bus.vld_ID && bus.ld_ID;
            dst_EX    <= bus.dst_addr_ID;
            we_DM     <= we_EX;
            dst_DM    <= dst_EX;
            // the newer producer (EX) takes priority over DM for each port
            byp0_EX_q <= nxt_byp0_EX;
            byp0_DM_q <= bus.vld_ID && hit0_DM && !nxt_byp0_EX;
            byp1_EX_q <= nxt_byp1_EX;
            byp1_DM_q <= bus.vld_ID && hit1_DM && !nxt_byp1_EX;
        end
    end

    assign bus.byp0_EX      = byp0_EX_q;
    assign bus.byp0_DM      = byp0_DM_q;
    assign bus.byp1_EX      = byp1_EX_q;
    assign bus.byp1_DM      = byp1_DM_q;
    assign bus.stall_IF_ID  = bus.stall_mem || load_use;
    assign bus.stall_ID_EX  = bus.stall_mem;
    assign bus.stall_EX_DM  = bus.stall_mem;
    assign bus.bubble_ID_EX = bubble;

endmodule

// File: tb/tb_hazard_bypass_ctrl.sv
// Bench for hazard_bypass_ctrl: directed pipeline scenarios followed by
// random instruction streams, checked against an in-flight instruction model.
module tb_hazard_bypass_ctrl;

    logic clk;
    logic rst;

    hazard_bypass_ctrl_if #(.REG_AW(4)) bus ();

    hazard_bypass_ctrl #(.REG_AW(4), .ZERO_REG(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the instructions in flight, youngest first
    // (stg[0] is in EX, stg[1] is in DM). A register-writing instruction
    // targeting R0 never produces a value.
    typedef struct packed {
        logic       wr;
        logic [3:0] rd;
        logic       ld;
    } slot_t;

    slot_t      stg [2];
    logic [3:0] exp_byp;   // {byp0_EX, byp0_DM, byp1_EX, byp1_DM}
    logic       prev_lu;
    logic       prev_sm;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Which in-flight stage supplies register a: 0 none, 1 EX, 2 DM
    function automatic int src_of(input logic [3:0] a);
        if (a == 4'd0) return 0;
        for (int s = 0; s < 2; s++)
            if (stg[s].wr && stg[s].rd == a) return s + 1;
        return 0;
    endfunction

    // One clock: drive ID at negedge, check controls, then check selects after posedge
    task automatic step(input logic r, input logic v, input logic r0, input logic r1,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic w, input logic [3:0] d, input logic l,
                        input logic f, input logic sm);
        logic  lu, bub;
        slot_t nx;
        @(negedge clk);
        rst             = r;
        bus.vld_ID      = v;
        bus.re0_ID      = r0;
        bus.re1_ID      = r1;
        bus.p0_addr_ID  = a0;
        bus.p1_addr_ID  = a1;
        bus.we_ID       = w;
        bus.dst_addr_ID = d;
        bus.ld_ID       = l;
        bus.flush       = f;
        bus.stall_mem   = sm;
        #1;
        lu  = v && !f && stg[0].ld &&
              ((r0 && src_of(a0) == 1) || (r1 && src_of(a1) == 1));
        bub = !sm && (lu || f);
        chk("stall_IF_ID",  8'(bus.stall_IF_ID),  8'(sm || lu));
        chk("stall_ID_EX",  8'(bus.stall_ID_EX),  8'(sm));
        chk("stall_EX_DM",  8'(bus.stall_EX_DM),  8'(sm));
        chk("bubble_ID_EX", 8'(bus.bubble_ID_EX), 8'(bub));
        if (r) begin
            stg[0]  = '0;
            stg[1]  = '0;
            exp_byp = '0;
        end else if (!sm) begin
            if (bub) begin
                exp_byp = '0;
                nx      = '0;
            end else begin
                exp_byp = {v && r0 && src_of(a0) == 1, v && r0 && src_of(a0) == 2,
                           v && r1 && src_of(a1) == 1, v && r1 && src_of(a1) == 2};
                nx      = '{wr: v && w, rd: d, ld: v && l};
            end
            stg[1] = stg[0];
            stg[0] = nx;
        end
        prev_lu = lu && !r;
        prev_sm = sm && !r;
        @(posedge clk);
        #1;
        chk("byp0_EX", 8'(bus.byp0_EX), 8'(exp_byp[3]));
        chk("byp0_DM", 8'(bus.byp0_DM), 8'(exp_byp[2]));
        chk("byp1_EX", 8'(bus.byp1_EX), 8'(exp_byp[1]));
        chk("byp1_DM", 8'(bus.byp1_DM), 8'(exp_byp[0]));
    endtask

    initial begin
        logic       c_v, c_r0, c_r1, c_w, c_l, c_f, c_sm, c_rst;
        logic [3:0] c_a0, c_a1, c_d;

        stg[0]  = '0;
        stg[1]  = '0;
        exp_byp = '0;
        prev_lu = 1'b0;
        prev_sm = 1'b0;
        rst = 1'b1;
        bus.vld_ID = 0; bus.re0_ID = 0; bus.re1_ID = 0;
        bus.p0_addr_ID = 0; bus.p1_addr_ID = 0; bus.we_ID = 0;
        bus.dst_addr_ID = 0; bus.ld_ID = 0; bus.flush = 0; bus.stall_mem = 0;

        // reset, including with the memory stall up
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ADD R3 then reader of R3 on p0: EX bypass
        step(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step(0, 1, 1, 0, 3, 0, 1, 4, 0, 0, 0);
        // ADD R3, NOP, reader of R3 on p1: DM bypass
        step(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 3, 1, 8, 0, 0, 0);
        // LW R5 then ADD reading R5: one stall, retry bypasses from DM
        step(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        step(0, 1, 1, 0, 5, 0, 1, 6, 0, 0, 0);
        step(0, 1, 1, 0, 5, 0, 1, 6, 0, 0, 0);
        // LW R0 then reader of R0: no hazard, no bypass
        step(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0, 1, 7, 0, 0, 0);
        // load-use with flush in the same cycle
        step(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        step(0, 1, 1, 0, 5, 0, 1, 6, 0, 1, 0);
        // load-use under memory stall, then released
        step(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        step(0, 1, 1, 0, 5, 0, 1, 6, 0, 0, 1);
        step(0, 1, 1, 0, 5, 0, 1, 6, 0, 0, 0);
        step(0, 1, 1, 0, 5, 0, 1, 6, 0, 0, 0);
        // reset in the middle of a load-use stall
        step(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        step(0, 1, 1, 0, 5, 0, 1, 6, 0, 0, 0);
        step(1, 1, 1, 0, 5, 0, 1, 6, 0, 0, 0);
        step(0, 1, 1, 0, 5, 0, 1, 6, 0, 0, 0);

        // random streams on a small register window so hazards are frequent
        c_v = 0; c_r0 = 0; c_r1 = 0; c_w = 0; c_l = 0; c_f = 0;
        c_a0 = 0; c_a1 = 0; c_d = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(prev_lu || prev_sm)) begin
                c_v  = ($urandom_range(0, 7) != 0);
                c_r0 = $urandom_range(0, 1);
                c_r1 = $urandom_range(0, 1);
                c_a0 = 4'($urandom_range(0, 3));
                c_a1 = 4'($urandom_range(0, 3));
                c_w  = ($urandom_range(0, 3) != 0);
                c_d  = 4'($urandom_range(0, 3));
                c_l  = ($urandom_range(0, 2) == 0);
            end
            if (!prev_sm) c_f = ($urandom_range(0, 7) == 0);
            c_sm  = ($urandom_range(0, 5) == 0);
            c_rst = ($urandom_range(0, 39) == 0);
            if (c_rst) c_f = 1'b0;
            step(c_rst, c_v, c_r0, c_r1, c_a0, c_a1, c_w, c_d, c_l, c_f, c_sm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
